sram_port_arbiter: RTL

- Shares one synchronous single-port SRAM between the instruction-fetch requester and the load/store requester of the multi-cycle core.
- Each requester uses a req/addr_ok/data_ok handshake. The arbiter grants at most one access per cycle and routes the read data, returned one cycle later, back to the owner.
- Sits between the core's IF/MEM state sequencing and the unified SRAM.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_starve_ctr.sv | 38 +++
 rtl/sram_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared encodings and defaults for the SRAM port arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package arb_pkg;

    // Owner of the single in-flight SRAM response.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    // Consecutive lost conflict cycles before fetch is forced to win.
    localparam int STARVE_MAX_DEF = 4;

endpackage : arb_pkg

// File: rtl/arb_starve_ctr.sv
// Saturating count of cycles the fetch side has waited while requesting.
// Latency: force_inst is registered-state derived, valid in the request cycle.
// Backpressure: none; counter clears whenever fetch is granted or idle.
//
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   i_inst_req    fetch side is requesting this cycle
//   i_inst_gnt    fetch side is granted this cycle
//   o_force_inst  count has reached STARVE_MAX, fetch must win a conflict
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_inst_req,
    input  logic i_inst_gnt,
    output logic o_force_inst
);

    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 4'd0;
        end else if (!i_inst_req || i_inst_gnt) begin
            r_cnt <= 4'd0;
        end else if (r_cnt != LP_MAX) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force_inst = (r_cnt == LP_MAX);

endmodule : arb_starve_ctr

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and load/store requesters.
// Latency: addr_ok combinational in request cycle; data_ok exactly one cycle later.
// Backpressure: none on responses; a losing requester simply holds req until addr_ok.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   inst_req/addr, inst_addr_ok      fetch request handshake
//   inst_data_ok/rdata               fetch response
//   data_req/wr/wstrb/addr/wdata     load/store request, data_addr_ok accept
//   data_data_ok/rdata               load data or store completion
//   sram_en/we/addr/wdata/rdata      synchronous SRAM, read data one cycle after en
//   perf_*                           grant/conflict counters (only with ARB_PERF_CNT_EN)
//
// Optional feature macro: ARB_PERF_CNT_EN adds three 32-bit performance counters.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_inst_grants,
    output logic [31:0]       perf_data_grants,
    output logic [31:0]       perf_conflicts,
`endif

    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    logic       r_rst_done;
    logic [1:0] r_owner;
    logic       r_resp_store;   // in-flight data response is a store completion

    logic w_force_inst;
    logic w_inst_gnt;
    logic w_data_gnt;
    logic w_conflict;

    // Grants are held off for one cycle after reset release so the SRAM and
    // the requesters see a clean first edge.
    assign w_conflict = r_rst_done & inst_req & data_req;
    assign w_inst_gnt = r_rst_done & inst_req & (~data_req | w_force_inst);
    assign w_data_gnt = r_rst_done & data_req & ~w_inst_gnt;

    arb_starve_ctr #(
        .STARVE_MAX   (STARVE_MAX)
    ) u_starve_ctr (
        .clk          (clk),
        .resetn       (resetn),
        .i_inst_req   (inst_req),
        .i_inst_gnt   (w_inst_gnt),
        .o_force_inst (w_force_inst)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Exactly one response can be in flight; reset drops it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner      <= OWN_NONE;
            r_resp_store <= 1'b0;
        end else begin
            if (w_inst_gnt) begin
                r_owner <= OWN_INST;
            end else if (w_data_gnt) begin
                r_owner <= OWN_DATA;
            end else begin
                r_owner <= OWN_NONE;
            end
            r_resp_store <= w_data_gnt & data_wr;
        end
    end

    assign inst_addr_ok = w_inst_gnt;
    assign data_addr_ok = w_data_gnt;

    assign sram_en    = w_inst_gnt | w_data_gnt;
    assign sram_we    = (w_data_gnt && data_wr) ? data_wstrb : 4'b0000;
    assign sram_addr  = w_inst_gnt ? inst_addr :
                        w_data_gnt ? data_addr : '0;
    // Fetch never writes, so only the data side contributes write data.
    assign sram_wdata = w_data_gnt ? data_wdata : 32'd0;

    assign inst_data_ok = (r_owner == OWN_INST);
    assign data_data_ok = (r_owner == OWN_DATA);

    // Store completions carry no data; SRAM read port content is meaningless then.
    assign inst_rdata = inst_data_ok ? sram_rdata : 32'd0;
    assign data_rdata = (data_data_ok && !r_resp_store) ? sram_rdata : 32'd0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_inst;
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_inst <= 32'd0;
            r_perf_data <= 32'd0;
            r_perf_conf <= 32'd0;
        end else begin
            if (w_inst_gnt) r_perf_inst <= r_perf_inst + 32'd1;
            if (w_data_gnt) r_perf_data <= r_perf_data + 32'd1;
            if (w_conflict) r_perf_conf <= r_perf_conf + 32'd1;
        end
    end

    assign perf_inst_grants = r_perf_inst;
    assign perf_data_grants = r_perf_data;
    assign perf_conflicts   = r_perf_conf;
`else
    // Conflict detection only feeds the performance counters.
    logic w_unused_conflict;
    assign w_unused_conflict = w_conflict;
`endif

endmodule : sram_port_arbiter
